// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD datapath.
// Imported by bcd_digit_adder and bcd_serial_addsub.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_ADJ     = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with optional nine's-complement of b.
// Ports: a_d/b_d digits, cin, inv (complement b) -> s_d, cout_d, bad_d (digit >9).
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   cin,
  input  logic                   inv,
  output logic [BCD_DIGIT_W-1:0] s_d,
  output logic                   cout_d,
  output logic                   bad_d
);

  logic [3:0] w_bd;
  logic [4:0] w_t;
  logic [3:0] w_adj;

  assign w_bd   = inv ? (BCD_MAX - b_d) : b_d;
  assign w_t    = {1'b0, a_d} + {1'b0, w_bd} + {4'b0, cin};
  // Adding 6 skips the six unused codes; the carry is taken from the compare.
  assign w_adj  = w_t[3:0] + BCD_ADJ;
  assign cout_d = (w_t > {1'b0, BCD_MAX});
  assign s_d    = cout_d ? w_adj : w_t[3:0];
  assign bad_d  = (a_d > BCD_MAX) | (b_d > BCD_MAX);

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/sub, one digit per clock LSD first, valid/ready both sides.
// Ports: clk, rst, in_valid/in_ready, a, b, sub, out_valid/out_ready, sum, cout, err.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

  state_e        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic          r_sub;
  logic          r_carry;
  logic          r_err_acc;
  logic [CW-1:0] r_cnt;

  logic [3:0]    w_s;
  logic          w_c;
  logic          w_bad;
  logic          w_err;
  logic [W+3:0]  w_cat;
  logic [W-1:0]  w_acc_nxt;

  bcd_digit_adder u_dig (
    .a_d    (r_a[3:0]),
    .b_d    (r_b[3:0]),
    .cin    (r_carry),
    .inv    (r_sub),
    .s_d    (w_s),
    .cout_d (w_c),
    .bad_d  (w_bad)
  );

  // New digit enters at the MSD end so the LSD lands in [3:0] last.
  assign w_cat     = {w_s, r_acc};
  assign w_acc_nxt = w_cat[W+3:4];
  assign w_err     = r_err_acc | w_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_err_acc <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a       <= a;
            r_b       <= b;
            r_sub     <= sub;
            r_carry   <= sub;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
            in_ready  <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_a       <= r_a >> 4;
          r_b       <= r_b >> 4;
          r_carry   <= w_c;
          r_err_acc <= w_err;
          r_acc     <= w_acc_nxt;
          r_cnt     <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            err       <= w_err;
            cout      <= w_err ? 1'b0 : w_c;
            sum       <= w_err ? '0 : w_acc_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: N=2 and N=4 instances, vector table + model.
// Scoreboard queues hold expected results; a negedge monitor compares them.
module tb_bcd_serial_addsub;

  typedef struct {
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] es;
    logic        ec;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv2 = 1'b0;
  logic        iv4 = 1'b0;
  logic [15:0] ta  = '0;
  logic [15:0] tb  = '0;
  logic        ts  = 1'b0;
  logic        ordy = 1'b1;

  logic        ir2, ov2, c2, e2;
  logic [7:0]  sum2;
  logic        ir4, ov4, c4, e4;
  logic [15:0] sum4;

  int checks = 0;
  int errors = 0;

  exp_t q2[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  bcd_serial_addsub #(.N_DIGITS(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .a(ta[7:0]), .b(tb[7:0]), .sub(ts),
    .out_valid(ov2), .out_ready(ordy),
    .sum(sum2), .cout(c2), .err(e2)
  );

  bcd_serial_addsub #(.N_DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(ta), .b(tb), .sub(ts),
    .out_valid(ov4), .out_ready(ordy),
    .sum(sum4), .cout(c4), .err(e4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int b2i(input logic [15:0] v, input int n);
    int r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [15:0] i2b(input int v, input int n);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < n; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input int n, input logic [15:0] a, b,
                       input logic s, output logic [15:0] es,
                       output logic ec);
    int m = (n == 2) ? 100 : 10000;
    int r;
    if (s) begin
      r  = b2i(a, n) - b2i(b, n);
      ec = (r >= 0);
      if (r < 0) r = r + m;
    end else begin
      r  = b2i(a, n) + b2i(b, n);
      ec = (r >= m);
      r  = r % m;
    end
    es = i2b(r, n);
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && ov2 && ordy) begin
      if (q2.size() == 0) chk("unexpected2", 1, 0);
      else begin
        e = q2.pop_front();
        chk("sum2", {24'b0, sum2}, {16'b0, e.sum});
        chk("cout2", {31'b0, c2}, {31'b0, e.c});
        chk("err2", {31'b0, e2}, {31'b0, e.e});
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && ov4 && ordy) begin
      if (q4.size() == 0) chk("unexpected4", 1, 0);
      else begin
        e = q4.pop_front();
        chk("sum4", {16'b0, sum4}, {16'b0, e.sum});
        chk("cout4", {31'b0, c4}, {31'b0, e.c});
        chk("err4", {31'b0, e4}, {31'b0, e.e});
      end
    end
  end

  // Drives one op (times are posedge+#1), checks latency; returns once
  // the result has been taken, or while it is held if ordy is low.
  task automatic op(input int n, input logic [15:0] a, b,
                    input logic s, input logic [15:0] es,
                    input logic ec, ee);
    exp_t x;
    int k;
    x.sum = es; x.c = ec; x.e = ee;
    if (n == 4) q4.push_back(x); else q2.push_back(x);
    k = 0;
    while (!((n == 4) ? ir4 : ir2) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) chk("ready_timeout", 0, 1);
    ta = a; tb = b; ts = s;
    if (n == 4) iv4 = 1'b1; else iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0; iv4 = 1'b0;
    ta = 16'h5A5A; tb = 16'hA5A5; ts = ~s;
    k = 0;
    while (!((n == 4) ? ov4 : ov2) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk($sformatf("latency%0d", n), k, n);
    if (ordy) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vt[$];
  logic [15:0] ra, rb, res;
  logic        rc;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt = '{
      '{2, 16'h0099, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{2, 16'h0045, 16'h0012, 1'b1, 16'h0033, 1'b1, 1'b0},
      '{2, 16'h0012, 16'h0045, 1'b1, 16'h0067, 1'b0, 1'b0},
      '{2, 16'h001A, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{2, 16'h0012, 16'h009F, 1'b1, 16'h0000, 1'b0, 1'b1},
      '{2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0},
      '{2, 16'h0050, 16'h0050, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{2, 16'h0037, 16'h0037, 1'b1, 16'h0000, 1'b1, 1'b0},
      '{2, 16'h0000, 16'h0001, 1'b1, 16'h0099, 1'b0, 1'b0},
      '{2, 16'h0028, 16'h0019, 1'b0, 16'h0047, 1'b0, 1'b0},
      '{4, 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0},
      '{4, 16'h1234, 16'h5678, 1'b1, 16'h5556, 1'b0, 1'b0},
      '{4, 16'h5000, 16'h0001, 1'b1, 16'h4999, 1'b1, 1'b0}
    };

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ir2", {31'b0, ir2}, 1);
    chk("rst_ov2", {31'b0, ov2}, 0);
    chk("rst_sum2", {24'b0, sum2}, 0);
    chk("rst_cout2", {31'b0, c2}, 0);
    chk("rst_err2", {31'b0, e2}, 0);
    chk("rst_ir4", {31'b0, ir4}, 1);
    chk("rst_ov4", {31'b0, ov4}, 0);

    foreach (vt[i])
      op(vt[i].n, vt[i].a, vt[i].b, vt[i].s, vt[i].es, vt[i].ec, vt[i].ee);

    // Backpressure: result and flags must hold while out_ready is low.
    ordy = 1'b0;
    op(2, 16'h0045, 16'h0012, 1'b0, 16'h0057, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, ov2}, 1);
      chk("bp_sum", {24'b0, sum2}, 32'h57);
      chk("bp_inrdy", {31'b0, ir2}, 0);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", {31'b0, ov2}, 0);
    chk("rel_inrdy", {31'b0, ir2}, 1);
    chk("rel_sumkeep", {24'b0, sum2}, 32'h57);
    op(2, 16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0, 1'b0);

    // Reset in the middle of an N=4 run.
    ta = 16'h1111; tb = 16'h2222; ts = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_ir4", {31'b0, ir4}, 1);
    chk("mrst_ov4", {31'b0, ov4}, 0);
    chk("mrst_sum4", {16'b0, sum4}, 0);
    chk("mrst_cout4", {31'b0, c4}, 0);
    @(posedge clk); #1;
    chk("mrst_ov4_stay", {31'b0, ov4}, 0);
    op(4, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Random add/sub vectors against the decimal model.
    for (int i = 0; i < 40; i++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < 4; d++) begin
        ra[4*d+:4] = 4'($urandom_range(9));
        rb[4*d+:4] = 4'($urandom_range(9));
      end
      if (i % 2 == 0) begin
        ra[15:8] = '0; rb[15:8] = '0;
        model(2, ra, rb, (i >= 20), res, rc);
        op(2, ra, rb, (i >= 20), res, rc, 1'b0);
      end else begin
        model(4, ra, rb, (i >= 20), res, rc);
        op(4, ra, rb, (i >= 20), res, rc, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    chk("q2_empty", q2.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
